// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: the read-mode selector used by every variant.
package fifo_pkg;

    // FIFO_STD: registered read, data appears one cycle after an accepted read.
    // FIFO_FWFT: head word is presented on data_out whenever the FIFO is not empty.
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

endpackage : fifo_pkg

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage array: one synchronous write port, one asynchronous read port.
module fifo_sdp_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write port: store the word on an accepted write.
    // NOTE: the array has no reset on purpose; occupancy is tracked by the pointers, and a reset
    // on a memory prevents it from mapping onto RAM primitives.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : fifo_sdp_ram

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with FWFT/standard read mode, occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow and synchronous flush.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         DEPTH      = 16,
    parameter fifo_mode_e MODE       = FIFO_FWFT,
    parameter int         AF_THRESH  = DEPTH - 2,
    parameter int         AE_THRESH  = 2,
    localparam int        PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wrst_n,
    input  logic                  flush,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("param_sync_fifo: DEPTH must be a power of 2 and >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("param_sync_fifo: AF_THRESH must lie in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("param_sync_fifo: AE_THRESH must lie in 0..DEPTH-1");
    end

    localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] AF_C    = (PTR_WIDTH + 1)'(AF_THRESH);
    localparam logic [PTR_WIDTH:0] AE_C    = (PTR_WIDTH + 1)'(AE_THRESH);

    // Pointers carry one extra MSB so a full lap is distinguishable from no movement.
    logic [PTR_WIDTH:0]    wptr_q, wptr_d;
    logic [PTR_WIDTH:0]    rptr_q, rptr_d;
    logic [PTR_WIDTH:0]    count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // A write into a full FIFO or a read from an empty one is refused rather than passed through.
    assign wr_acc = w_en && !full_q && !flush;
    assign rd_acc = r_en && !empty_q && !flush;

    fifo_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wptr_q[PTR_WIDTH-1:0]),
        .wdata_i (data_in),
        .raddr_i (rptr_q[PTR_WIDTH-1:0]),
        .rdata_o (ram_rdata)
    );

    // Next-state: advance pointers and count on accepted transfers, derive flags from the new count.
    // NOTE: every _d signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q  | (w_en & full_q);
        underflow_d = underflow_q | (r_en & empty_q);
        rd_valid_d  = rd_acc;
        dout_d      = dout_q;

        if (wr_acc) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_acc) begin
            rptr_d = rptr_q + 1'b1;
            dout_d = ram_rdata;
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            rd_valid_d  = 1'b0;
            dout_d      = '0;
        end

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
    end

    // State register: asynchronous clear to the empty state, otherwise load next state.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge wrst_n) begin
        if (!wrst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            dout_q      <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_valid_q  <= rd_valid_d;
            dout_q      <= dout_d;
        end
    end

    // FWFT shows the head word directly (forced to zero while empty so stale memory never shows);
    // STD presents the word captured on the last accepted read.
    assign data_out     = (MODE == FIFO_FWFT) ? (empty_q ? '0 : ram_rdata) : dout_q;
    assign rd_valid     = (MODE == FIFO_FWFT) ? !empty_q : rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule : param_sync_fifo

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench: an FWFT and a STD instance share one stimulus stream and are both
// compared against a queue-based reference model after every clock edge.
module tb_param_sync_fifo;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       wrst_n;
    logic       flush, w_en, r_en;
    logic [7:0] data_in;

    logic [7:0] data_out_f, data_out_s;
    logic       rd_valid_f, rd_valid_s;
    logic       full_f, full_s, empty_f, empty_s;
    logic       af_f, af_s, ae_f, ae_s;
    logic [4:0] count_f, count_s;
    logic       ov_f, ov_s, un_f, un_s;

    int         checks = 0;
    int         errors = 0;

    // Reference model state.
    int         cnt = 0;
    logic [7:0] sb[$];
    bit         m_ov = 1'b0;
    bit         m_un = 1'b0;
    logic [7:0] std_exp = 8'h00;

    always #5 clk = ~clk;

    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .MODE(FIFO_FWFT)) u_fwft (
        .clk(clk), .wrst_n(wrst_n), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(data_out_f), .rd_valid(rd_valid_f), .full(full_f), .empty(empty_f),
        .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
        .overflow(ov_f), .underflow(un_f)
    );

    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .MODE(FIFO_STD)) u_std (
        .clk(clk), .wrst_n(wrst_n), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(data_out_s), .rd_valid(rd_valid_s), .full(full_s), .empty(empty_s),
        .almost_full(af_s), .almost_empty(ae_s), .count(count_s),
        .overflow(ov_s), .underflow(un_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        cnt     = 0;
        sb.delete();
        m_ov    = 1'b0;
        m_un    = 1'b0;
        std_exp = 8'h00;
    endtask

    // Compare every output of both instances against the model.
    task automatic check_state(input bit exp_rv_std);
        logic [7:0] head;
        head = (cnt > 0) ? sb[0] : 8'h00;
        check("count_f",    32'(count_f),    32'(cnt));
        check("count_s",    32'(count_s),    32'(cnt));
        check("full",       32'(full_f),     32'(cnt == 16));
        check("empty",      32'(empty_f),    32'(cnt == 0));
        check("almost_full",32'(af_f),       32'(cnt >= 14));
        check("almost_empty",32'(ae_f),      32'(cnt <= 2));
        check("overflow",   32'(ov_f),       32'(m_ov));
        check("underflow",  32'(un_f),       32'(m_un));
        check("overflow_s", 32'(ov_s),       32'(m_ov));
        check("underflow_s",32'(un_s),       32'(m_un));
        check("rd_valid_f", 32'(rd_valid_f), 32'(cnt > 0));
        check("data_out_f", 32'(data_out_f), 32'(head));
        check("rd_valid_s", 32'(rd_valid_s), 32'(exp_rv_std));
        check("data_out_s", 32'(data_out_s), 32'(std_exp));
    endtask

    // One clock cycle of stimulus; the model decides acceptance from its own occupancy.
    task automatic op(input bit w, input logic [7:0] d, input bit r, input bit fl);
        bit         wacc, racc;
        logic [7:0] popped;
        w_en    = w;
        data_in = d;
        r_en    = r;
        flush   = fl;
        wacc    = w && (cnt < 16) && !fl;
        racc    = r && (cnt > 0) && !fl;
        if (racc) check("fwft_head", 32'(data_out_f), 32'(sb[0]));
        @(posedge clk);
        #1;
        if (fl) begin
            model_clear();
        end else begin
            if (w && cnt == 16) m_ov = 1'b1;
            if (r && cnt == 0)  m_un = 1'b1;
            if (racc) begin
                popped  = sb.pop_front();
                std_exp = popped;
                cnt--;
            end
            if (wacc) begin
                sb.push_back(d);
                cnt++;
            end
        end
        w_en  = 1'b0;
        r_en  = 1'b0;
        flush = 1'b0;
        check_state(racc);
    endtask

    initial begin
        wrst_n  = 1'b0;
        flush   = 1'b0;
        w_en    = 1'b0;
        r_en    = 1'b0;
        data_in = 8'h00;
        #12;
        check_state(1'b0);
        @(negedge clk);
        wrst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state(1'b0);

        // 1: asynchronous reset in mid-cycle with seven words stored.
        for (int i = 0; i < 7; i++) op(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        op(1'b0, 8'h00, 1'b1, 1'b0);
        op(1'b1, 8'h47, 1'b0, 1'b0);
        check("pre_reset_count", 32'(count_f), 32'd7);
        #2;
        wrst_n = 1'b0;
        #1;
        model_clear();
        check_state(1'b0);
        @(negedge clk);
        wrst_n = 1'b1;

        // 2: fill to full, overflow on 17th write, drain in order.
        for (int i = 0; i < 16; i++) op(1'b1, 8'(i), 1'b0, 1'b0);
        op(1'b1, 8'hAA, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) op(1'b0, 8'h00, 1'b1, 1'b0);
        check("drained_empty", 32'(empty_f), 32'd1);

        // 3: read on empty sets underflow and leaves data untouched; flush clears stickies.
        op(1'b0, 8'h00, 1'b1, 1'b0);
        op(1'b0, 8'h00, 1'b0, 1'b1);

        // 4: preload five, then simultaneous read+write for forty cycles.
        for (int i = 0; i < 5; i++) op(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) op(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) op(1'b0, 8'h00, 1'b1, 1'b0);

        // 5: single word latency in both modes; STD valid lasts one cycle.
        op(1'b0, 8'h00, 1'b0, 1'b1);
        op(1'b1, 8'h5A, 1'b0, 1'b0);
        check("fwft_5a", 32'(data_out_f), 32'h5A);
        op(1'b0, 8'h00, 1'b1, 1'b0);
        check("std_5a", 32'(data_out_s), 32'h5A);
        op(1'b0, 8'h00, 1'b0, 1'b0);

        // 6: flush with a concurrent write discards it; next read yields fresh data.
        for (int i = 0; i < 9; i++) op(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        op(1'b1, 8'h33, 1'b0, 1'b1);
        op(1'b1, 8'h77, 1'b0, 1'b0);
        check("fresh_after_flush", 32'(data_out_f), 32'h77);
        op(1'b0, 8'h00, 1'b1, 1'b0);
        check("std_fresh", 32'(data_out_s), 32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_param_sync_fifo
